// File: rtl/uart_pkg.sv
// Shared UART types and default constants for the receive path and the baud tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DEF_DBIT      = 8;
    localparam int DEF_SB_TICK   = 16;
    localparam int DEF_DVSR      = 163;
    localparam int DEF_DVSR_BITS = 9;
    localparam int MID_START     = 7;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-clock tick every DVSR clocks (16x oversample rate).
module baud_tick_gen #(
    parameter int DVSR      = 163,
    parameter int DVSR_BITS = 9
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam logic [DVSR_BITS-1:0] LAST = DVSR_BITS'(DVSR - 1);

    logic [DVSR_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DVSR_BITS'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronizes RsRx, recovers 8N1-style frames at 16x oversampling,
// strobes each byte out with a framing-error flag and parks in BREAK while the line is held low.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DBIT      = DEF_DBIT,
    parameter int SB_TICK   = DEF_SB_TICK,
    parameter int DVSR      = DEF_DVSR,
    parameter int DVSR_BITS = DEF_DVSR_BITS
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done,
    output logic            o_frame_err,
    output logic            o_busy
);

    // s must also reach SB_TICK-1 when 1.5 or 2 stop bits are configured
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            tick;
    logic            rx_meta_q, rx_s_q;
    rx_state_t       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;

    baud_tick_gen #(
        .DVSR      (DVSR),
        .DVSR_BITS (DVSR_BITS)
    ) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_W'(MID_START)) begin
                        if (!rx_s_q) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == N_W'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        dout_d      = b_q;
                        rx_done_d   = 1'b1;
                        frame_err_d = ~rx_s_q;
                        state_d     = rx_s_q ? IDLE : BREAK;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy lags the state register by one clock
    assign busy_d = (state_q != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= i_rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_dout      = dout_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench: a default-rate receiver and a fast (DVSR=4, 2 stop bits) receiver, with a
// per-instance queue of expected bytes popped on every done strobe.
module tb_uart_rx_frame;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    localparam int BCLK0 = 16 * 163;
    localparam int BCLK1 = 16 * 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       done0, done1, ferr0, ferr1, busy0, busy1;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc1 = 0;
    int   done_cyc1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    uart_rx_frame dut0 (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx        (rx0),
        .o_dout      (dout0),
        .o_rx_done   (done0),
        .o_frame_err (ferr0),
        .o_busy      (busy0)
    );

    uart_rx_frame #(
        .DBIT      (8),
        .SB_TICK   (32),
        .DVSR      (4),
        .DVSR_BITS (3)
    ) dut1 (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx        (rx1),
        .o_dout      (dout1),
        .o_rx_done   (done1),
        .o_frame_err (ferr1),
        .o_busy      (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            checks++;
            assert (q0.size() != 0) else begin
                errors++;
                $error("FAIL dflt_unexpected_strobe: dout=%02h ferr=%0b, expected no strobe", dout0, ferr0);
            end
            if (q0.size() != 0) begin
                exp_t e;
                e = q0.pop_front();
                checks++;
                assert (dout0 === e.d) else begin
                    errors++;
                    $error("FAIL dflt_dout: got %02h expected %02h", dout0, e.d);
                end
                checks++;
                assert (ferr0 === e.fe) else begin
                    errors++;
                    $error("FAIL dflt_ferr: got %0b expected %0b", ferr0, e.fe);
                end
            end
        end else if (ferr0 === 1'b1) begin
            checks++;
            assert (done0 === 1'b1) else begin
                errors++;
                $error("FAIL dflt_ferr_alone: ferr=1 with done=%0b, expected done=1", done0);
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            done_cyc1 = cyc;
            checks++;
            assert (q1.size() != 0) else begin
                errors++;
                $error("FAIL fast_unexpected_strobe: dout=%02h ferr=%0b, expected no strobe", dout1, ferr1);
            end
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                checks++;
                assert (dout1 === e.d) else begin
                    errors++;
                    $error("FAIL fast_dout: got %02h expected %02h", dout1, e.d);
                end
                checks++;
                assert (ferr1 === e.fe) else begin
                    errors++;
                    $error("FAIL fast_ferr: got %0b expected %0b", ferr1, e.fe);
                end
            end
        end else if (ferr1 === 1'b1) begin
            checks++;
            assert (done1 === 1'b1) else begin
                errors++;
                $error("FAIL fast_ferr_alone: ferr=1 with done=%0b, expected done=1", done1);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit inst, input logic v, input int n);
        if (inst) rx1 = v;
        else      rx0 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input bit inst, input logic [7:0] d, input int bclk,
                             input int nstop, input logic stop_val);
        if (inst) start_cyc1 = cyc;
        drive(inst, 1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(inst, d[i], bclk);
        drive(inst, stop_val, nstop * bclk);
    endtask

    task automatic wait_drain(input bit inst, input int max_clk, input string tag);
        int k;
        k = 0;
        while (((inst ? q1.size() : q0.size()) != 0) && k < max_clk) begin
            @(negedge clk);
            k++;
        end
        chk(tag, inst ? q1.size() : q0.size(), 0);
    endtask

    initial begin
        int lat;

        // reset held with idle line
        repeat (5) @(negedge clk);
        chk("rst_dout0", dout0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_ferr0", ferr0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_state0", dut0.state_q, IDLE);
        chk("rst_dout1", dout1, 0);
        chk("rst_busy1", busy1, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 3-clock low glitch on both lines
        rx0 = 1'b0;
        rx1 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("glitch_busy_high0", busy0, 1);
        chk("glitch_busy_high1", busy1, 1);
        repeat (1500) @(negedge clk);
        chk("glitch_busy_low0", busy0, 0);
        chk("glitch_state0", dut0.state_q, IDLE);
        chk("glitch_dout0", dout0, 0);
        chk("glitch_busy_low1", busy1, 0);

        // reset during data bit 4 of 0x3C on the fast receiver; sender aborts too
        drive(1'b1, 1'b0, BCLK1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'(8'h3C >> i), BCLK1);
        drive(1'b1, 1'b1, BCLK1 / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy1", busy1, 0);
        chk("midrst_state1", dut1.state_q, IDLE);
        repeat (1500) @(negedge clk);
        chk("midrst_dout1", dout1, 0);
        q1.push_back('{d: 8'h81, fe: 1'b0});
        send_byte(1'b1, 8'h81, BCLK1, 2, 1'b1);
        wait_drain(1'b1, 200, "drain_81");

        // short divisor frames and strobe latency
        q1.push_back('{d: 8'h00, fe: 1'b0});
        send_byte(1'b1, 8'h00, BCLK1, 2, 1'b1);
        wait_drain(1'b1, 200, "drain_00");
        lat = done_cyc1 - start_cyc1;
        checks++;
        assert (lat >= 668 && lat <= 708) else begin
            errors++;
            $error("FAIL fast_latency: got %0d clocks expected 668..708", lat);
        end
        q1.push_back('{d: 8'hFF, fe: 1'b0});
        send_byte(1'b1, 8'hFF, BCLK1, 2, 1'b1);
        wait_drain(1'b1, 200, "drain_ff");

        // framing error followed by a held-low line
        q1.push_back('{d: 8'h5A, fe: 1'b1});
        send_byte(1'b1, 8'h5A, BCLK1, 2, 1'b0);
        drive(1'b1, 1'b0, 3 * 11 * BCLK1);
        chk("ferr_drained", q1.size(), 0);
        chk("break_busy1", busy1, 1);
        chk("break_state1", dut1.state_q, BREAK);
        drive(1'b1, 1'b1, 10);
        chk("break_exit_busy1", busy1, 0);
        chk("break_exit_state1", dut1.state_q, IDLE);

        // bit period 3% slow, then 3% fast
        q1.push_back('{d: 8'h96, fe: 1'b0});
        send_byte(1'b1, 8'h96, 66, 2, 1'b1);
        wait_drain(1'b1, 200, "drain_96_slow");
        q1.push_back('{d: 8'h96, fe: 1'b0});
        send_byte(1'b1, 8'h96, 62, 2, 1'b1);
        wait_drain(1'b1, 200, "drain_96_fast");

        // nominal rate, back-to-back frames
        q0.push_back('{d: 8'hA5, fe: 1'b0});
        send_byte(1'b0, 8'hA5, BCLK0, 1, 1'b1);
        q0.push_back('{d: 8'h03, fe: 1'b0});
        send_byte(1'b0, 8'h03, BCLK0, 1, 1'b1);
        wait_drain(1'b0, 3000, "drain_03");
        chk("final_dout0", dout0, 8'h03);
        repeat (5) @(negedge clk);
        chk("final_busy0", busy0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
